// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 compression controller:
// word width, round constants, initial hash value and FSM state encoding.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_compress_ctrl_if.sv
// Block-in / digest-out bus of the compression controller.
interface sha256_compress_ctrl_if;
  import sha256_pkg::*;

  // A block transfers on a rising clock edge where block_valid && block_ready.
  // The source holds block/hash_in stable with block_valid high until then;
  // digest_valid is a one-cycle pulse with no back-pressure.
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block;
  logic [255:0] hash_in;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
  state_t       dbg_state;

  modport master (
    output block_valid, block, hash_in,
    input  block_ready, digest, digest_valid, busy, dbg_state
  );

  modport slave (
    input  block_valid, block, hash_in,
    output block_ready, digest, digest_valid, busy, dbg_state
  );

endinterface

// File: rtl/func_ch.sv
// Choose: each bit of e selects between f and g.
module func_ch
  import sha256_pkg::*;
(
  input  word_t e,
  input  word_t f,
  input  word_t g,
  output word_t y
);
  assign y = (e & f) ^ (~e & g);
endmodule

// File: rtl/func_maj.sv
// Bitwise majority of a, b, c.
module func_maj
  import sha256_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  output word_t y
);
  assign y = (a & b) ^ (a & c) ^ (b & c);
endmodule

// File: rtl/func_sigma0.sv
// Big-sigma-0 of the SHA-256 round, applied to working variable a.
module func_sigma0
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
endmodule

// File: rtl/func_sigma1.sv
// Big-sigma-1 of the SHA-256 round, applied to working variable e.
module func_sigma1
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t y
);
  assign y = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
endmodule

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h (index 0..7),
// round constant and schedule word in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  word_t cur [8],
  input  word_t k,
  input  word_t w,
  output word_t nxt [8]
);
  word_t s0, s1, ch, maj, t1, t2;

  func_sigma0 u_sigma0 (.x(cur[0]), .y(s0));
  func_sigma1 u_sigma1 (.x(cur[4]), .y(s1));
  func_ch     u_ch     (.e(cur[4]), .f(cur[5]), .g(cur[6]), .y(ch));
  func_maj    u_maj    (.a(cur[0]), .b(cur[1]), .c(cur[2]), .y(maj));

  assign t1 = cur[7] + s1 + ch + k + w;
  assign t2 = s0 + maj;

  assign nxt[0] = t1 + t2;
  assign nxt[1] = cur[0];
  assign nxt[2] = cur[1];
  assign nxt[3] = cur[2];
  assign nxt[4] = cur[3] + t1;
  assign nxt[5] = cur[4];
  assign nxt[6] = cur[5];
  assign nxt[7] = cur[6];
endmodule

// File: rtl/sha256_compress_ctrl.sv
// Sequences one SHA-256 compression: 64 rounds at one per clock, a sliding
// 16-word message schedule, and the final chaining-value add.
module sha256_compress_ctrl
  import sha256_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  sha256_compress_ctrl_if.slave bus
);

  state_t       state, state_nxt;
  logic [5:0]   cnt;
  word_t        v     [8];
  word_t        v_nxt [8];
  word_t        hh    [8];
  word_t        w     [16];
  word_t        w_new;
  logic [255:0] digest_r;
  logic         digest_valid_r;
  logic         accept;

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign accept = bus.block_valid && bus.block_ready;

  always_comb begin
    state_nxt       = state;
    bus.block_ready = 1'b0;
    bus.busy        = 1'b0;
    case (state)
      IDLE: begin
        bus.block_ready = 1'b1;
        if (bus.block_valid) state_nxt = ROUND;
      end
      ROUND: begin
        bus.busy = 1'b1;
        if (cnt == 6'd63) state_nxt = FINAL;
      end
      FINAL: begin
        bus.busy  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Schedule word for round t+16, formed from the window before it shifts.
  assign w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

  sha256_round u_round (
    .cur (v),
    .k   (K[cnt]),
    .w   (w[0]),
    .nxt (v_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      digest_r       <= '0;
      digest_valid_r <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        v[i]  <= '0;
        hh[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      digest_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            for (int i = 0; i < 8; i++) begin
              hh[i] <= bus.hash_in[255-32*i -: 32];
              v[i]  <= bus.hash_in[255-32*i -: 32];
            end
            for (int i = 0; i < 16; i++) w[i] <= bus.block[511-32*i -: 32];
          end
        end
        ROUND: begin
          cnt <= cnt + 6'd1;
          for (int i = 0; i < 8; i++) v[i] <= v_nxt[i];
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) digest_r[255-32*i -: 32] <= hh[i] + v[i];
          digest_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.digest       = digest_r;
  assign bus.digest_valid = digest_valid_r;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Bench for sha256_compress_ctrl: reference compression model feeding a
// scoreboard, known-answer digests, latency, input-ignore and reset cases.
module tb_sha256_compress_ctrl;
  import sha256_pkg::*;

  localparam logic [255:0] IV_W  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] ABC_B = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMP_B = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMP_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sha256_compress_ctrl_if bus ();

  sha256_compress_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int n_dv     = 0;
  int viol     = 0;
  logic prev_dv = 1'b0;
  logic [255:0] last_digest = '0;
  logic [255:0] exp_q [$];
  int           acc_q [$];

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic word_t m_rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression with the full 64-word expanded schedule.
  function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
    word_t ws [64];
    word_t a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) ws[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      ws[t] = (m_rotr(ws[t-2], 17) ^ m_rotr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
            + (m_rotr(ws[t-15], 7) ^ m_rotr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (m_rotr(e, 6) ^ m_rotr(e, 11) ^ m_rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + ws[t];
      t2 = (m_rotr(a, 2) ^ m_rotr(a, 13) ^ m_rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    ncyc++;
    if (bus.busy && bus.block_ready) viol++;
    if (bus.digest_valid && prev_dv) viol++;
    prev_dv = bus.digest_valid;
    if (bus.digest_valid) begin
      n_dv++;
      last_digest = bus.digest;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_digest_valid", 256'd1, 256'd0);
      end else begin
        check_eq("digest", bus.digest, exp_q.pop_front());
        check_eq("latency", 256'(ncyc - acc_q.pop_front() - 1), 256'd65);
      end
    end
  end

  // driver: present a block and hold it until accepted
  task automatic send_block(input logic [511:0] blk, input logic [255:0] hin, output int acc);
    int n;
    @(negedge clk);
    bus.block_valid = 1'b1;
    bus.block       = blk;
    bus.hash_in     = hin;
    n = 0;
    while (!bus.block_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_timeout", 256'(n >= 300), 256'd0);
    @(posedge clk);
    acc = ncyc;
    exp_q.push_back(ref_compress(blk, hin));
    acc_q.push_back(ncyc);
    #1 bus.block_valid = 1'b0;
  endtask

  task automatic wait_dv(input int target);
    int n;
    n = 0;
    while (n_dv < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("digest_valid_timeout", 256'(n_dv >= target), 256'd1);
  endtask

  initial begin
    int acc1, acc2, acc;
    logic [511:0] rb;
    logic [255:0] rh;
    bus.block_valid = 1'b0;
    bus.block       = '0;
    bus.hash_in     = '0;

    // reset state
    #12;
    check_eq("rst_digest", bus.digest, 256'd0);
    check_eq("rst_dv", 256'(bus.digest_valid), 256'd0);
    check_eq("rst_busy", 256'(bus.busy), 256'd0);
    check_eq("rst_ready", 256'(bus.block_ready), 256'd1);
    check_eq("rst_state", 256'(bus.dbg_state), 256'(IDLE));
    @(posedge clk);
    #1 rst = 1'b0;

    // "abc" with input noise during ROUND
    send_block(ABC_B, IV_W, acc);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.block_valid = 1'($urandom_range(0, 1));
      bus.block       = rand_block();
      bus.hash_in     = {8{32'($urandom)}};
    end
    bus.block_valid = 1'b0;
    wait_dv(1);
    check_eq("abc_kat", last_digest, ABC_D);
    repeat (5) @(negedge clk);
    check_eq("digest_hold", bus.digest, ABC_D);

    // empty message
    send_block(EMP_B, IV_W, acc);
    wait_dv(2);
    check_eq("empty_kat", last_digest, EMP_D);

    // two-block message, second block chained back-to-back
    send_block(TWO_B1, IV_W, acc1);
    send_block(TWO_B2, ref_compress(TWO_B1, IV_W), acc2);
    check_eq("b2b_accept_gap", 256'(acc2 - acc1), 256'd66);
    wait_dv(4);
    check_eq("two_block_kat", last_digest, TWO_D);
    check_eq("two_block_total", 256'(ncyc - acc1), 256'd132);

    // random blocks and chaining values
    for (int i = 0; i < 3; i++) begin
      rb = rand_block();
      rh = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send_block(rb, rh, acc);
    end
    wait_dv(7);

    // reset during round 30: block abandoned
    send_block(EMP_B, IV_W, acc);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    #2;
    check_eq("midrst_digest", bus.digest, 256'd0);
    check_eq("midrst_dv", 256'(bus.digest_valid), 256'd0);
    check_eq("midrst_busy", 256'(bus.busy), 256'd0);
    check_eq("midrst_ready", 256'(bus.block_ready), 256'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (80) @(negedge clk);
    check_eq("no_dv_after_abort", 256'(n_dv), 256'd7);
    send_block(EMP_B, IV_W, acc);
    wait_dv(8);
    check_eq("empty_after_rst", last_digest, EMP_D);

    repeat (3) @(negedge clk);
    check_eq("protocol_violations", 256'(viol), 256'd0);
    check_eq("scoreboard_empty", 256'(exp_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/sha256_compress_ctrl.md
# sha256_compress_ctrl

Sequencer for one SHA-256 compression: accepts a 512-bit message block and a 256-bit chaining value, runs the 64 rounds at one round per clock through the existing Σ0/Σ1/Ch/Maj round datapath, maintains the 16-word message-schedule window, and produces the updated 256-bit hash. It sits between the message padder/block buffer and the multi-block hash accumulator.

## Interface

Parameters: none; all constants come from `sha256_pkg`.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `block_valid`  in  1  block and chaining value are valid
- `block_ready`  out  1  controller can accept a block; high only in IDLE
- `block`  in  512  message block; W0 = `block[511:480]` … W15 = `block[31:0]`
- `hash_in`  in  256  chaining value; H0 = `hash_in[255:224]` … H7 = `hash_in[31:0]`
- `digest`  out  256  updated hash, same packing as `hash_in`
- `digest_valid`  out  1  one-cycle pulse: `digest` was updated this cycle
- `busy`  out  1  high in ROUND and FINAL

## Operation

- States: IDLE, ROUND, FINAL.
  - IDLE → ROUND when `block_valid && block_ready`.
  - ROUND → FINAL at the edge where round counter = 63.
  - FINAL → IDLE unconditionally.
- Accept edge:
  - Latch `hash_in` into H0–H7.
  - Load a..h from `hash_in` and W[0..15] from `block`.
  - Clear the 6-bit round counter.
- Each ROUND edge (round t):
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[0]; T2 = Σ0(a) + Maj(a,b,c).
  - Shift a..h: h←g … e←d+T1 … a←T1+T2.
  - Shift window: W[i]←W[i+1] for i = 0..14.
  - W[15] ← σ1(W[14]) + W[9] + σ0(W[1]) + W[0], using pre-shift values.
  - Counter increments; it wraps 63→0.
  - The window update runs every round. Schedule words computed after round 47 are unused and harmless.
- FINAL edge:
  - `digest` ← {H0+a, …, H7+h}.
  - `digest_valid` ← 1 for exactly one cycle.
- Arithmetic: all sums are 32-bit modulo 2^32. Carries are discarded.
- `digest` holds its value until the next FINAL edge.
- `block_valid` outside IDLE is ignored. A block is never queued or dropped silently: the source holds it until `block_ready`.
- Inputs are sampled only on the accept edge. Changes to `block`/`hash_in` during ROUND have no effect.
- Reset (asynchronous, any state, including mid-round):
  - state = IDLE; counter = 0; a..h, W and H latches = 0.
  - `digest` = 0, `digest_valid` = 0, `busy` = 0, `block_ready` = 1.
  - An in-flight block is abandoned and no `digest_valid` is produced for it.

## Timing

- Let accept edge = E0. Round t completes at edge E(t+1). The FINAL add happens at E65.
- `digest_valid` is high during the cycle after E65.
- Latency from accept to `digest_valid` is 65 clocks. Throughput is one block per 66 clocks.
- `block_ready` returns high in the same cycle `digest_valid` is high. A block presented then is accepted at the next edge (back-to-back chaining).
- `block_ready` and `busy` are decoded combinationally from the state register. All other outputs are registered.

## Structure

- `sha256_pkg` contains:
  - word-width constant 32;
  - the 64-entry K table;
  - the 8-word initial hash value IV;
  - the state enum {IDLE, ROUND, FINAL}.
- Sub-module `sha256_round`: combinational single round, (a..h, K, W) → (a'..h'). It instantiates the existing `func_sigma0`, Σ1, Ch and Maj blocks.
- The σ0/σ1 schedule functions, counter, FSM, window and final adders live in `sha256_compress_ctrl`.

## Test plan

- "abc" case: `block` = 0x61626380, 14×0x00000000, 0x00000018; `hash_in` = IV.
  - `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - `digest_valid` exactly 65 clocks after accept.
- Empty message: `block` = 0x80000000 followed by 15 zero words; `hash_in` = IV.
  - `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": chain the first digest into `hash_in`, presenting block 2 in the `digest_valid` cycle.
  - Final `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - 132 clocks from first accept.
- Ignored input: toggle `block_valid` and change `block` during ROUND.
  - No extra accept; "abc" digest unchanged; `block_ready` low throughout ROUND/FINAL.
- Reset mid-operation: assert `rst` at round 30, release it, then send the empty-message block.
  - All outputs 0 and `block_ready` = 1 during reset.
  - No `digest_valid` for the abandoned block.
  - Correct empty-message digest afterwards.
